// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline sequencer and its register banks:
// sequencer state encoding plus default register-address width and flush length.
package mips_pipe_pkg;

  localparam int RA_W_DEF     = 5;
  localparam int INIT_CYC_DEF = 4;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_ld_use_detect.sv
// Load-use comparator: flags when the ID instruction reads the register a load
// in EX is about to write. Register 0 is hard-wired and never a hazard.
module ld_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            ex_load,
  input  logic [RA_W-1:0] ex_rt,
  output logic            hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs && (id_rs == ex_rt);
  assign rt_hit = id_use_rt && (id_rt == ex_rt);
  assign hazard = ex_load && (ex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-bank sequencer: post-clear flush, load-use stall, taken-branch flush,
// data-memory wait stall and memory-timeout halt. Bank controls are decoded
// combinationally from state and inputs so they act in the same cycle.
// Handshake: mem_req/mem_ready -- an access completes in any cycle where both
// are high; mem_req high with mem_ready low freezes PC..EX/MEM and bubbles MEM/WB.
// Optional macro STALL_CNT_EN adds the stall_cnt output and its counter.
// dbg_state exposes the sequencer state for checkers.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int RA_W     = RA_W_DEF,
  parameter int INIT_CYC = INIT_CYC_DEF,
  parameter int MEM_TMO  = 15
`ifdef STALL_CNT_EN
  , parameter int CNT_W  = 32
`endif
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            ex_load,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            ex_br_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            mem_err,
  output logic [1:0]      dbg_state
`ifdef STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int         IC_W     = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(INIT_CYC - 1);
  localparam logic [8:0] TMO9     = 9'(MEM_TMO);

  state_e          state_q, state_d;
  logic [IC_W-1:0] init_cnt_q, init_cnt_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            ld_use;
  logic            mem_stall;

  ld_use_detect #(.RA_W(RA_W)) u_ld_use (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .ex_load   (ex_load),
    .ex_rt     (ex_rt),
    .hazard    (ld_use)
  );

  assign mem_stall = mem_req && !mem_ready;
  assign mem_err   = mem_err_q;
  assign dbg_state = state_q;

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state and bank-control decode; defaults hold everything idle.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (state_q)
      ST_INIT: begin
        {ifid_en, idex_en, exmem_en, memwb_en}             = 4'b1111;
        {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
        if (init_cnt_q == IC_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (mem_stall) begin
          // Freeze PC through EX/MEM; branch/load-use re-evaluated after the wait.
          memwb_en    = 1'b1;
          memwb_flush = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_cnt_d  = 8'd1;
        end else if (ex_br_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (ld_use) begin
          // Hold PC and IF/ID one cycle, inject a bubble into ID/EX.
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          // Access completes now, so this cycle already advances.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          memwb_en    = 1'b1;
          memwb_flush = 1'b1;
          if (({1'b0, wait_cnt_q} + 9'd1) >= TMO9) begin
            state_d   = ST_HALT;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Stall counter: cycles in RUN/MEM_WAIT where the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_en)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors push expected control words into
// a queue; a negedge monitor pops and compares one word per cycle.
module tb_pipe_hazard_ctrl;
  import mips_pipe_pkg::*;

  localparam int W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_use_rs = 1'b0, id_use_rt = 1'b0, ex_load = 1'b0;
  logic ex_br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err;
  logic [1:0] dbg_state;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .clear(clear),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_load(ex_load), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .mem_err(mem_err),
    .dbg_state(dbg_state)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit stim_done = 1'b0;

  function automatic logic [W-1:0] mk(logic pc, logic [3:0] en, logic [3:0] fl,
                                      logic err, logic [1:0] st);
    return {pc, en, fl, err, st};
  endfunction

  // Expected control words: {pc_en, en[ifid..memwb], flush[ifid..memwb], mem_err, state}
  function automatic logic [W-1:0] w_init();       return mk(1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0); endfunction
  function automatic logic [W-1:0] w_run(logic e); return mk(1'b1, 4'b1111, 4'b0000, e,    2'd1); endfunction
  function automatic logic [W-1:0] w_lu();         return mk(1'b0, 4'b0111, 4'b0100, 1'b0, 2'd1); endfunction
  function automatic logic [W-1:0] w_br();         return mk(1'b1, 4'b1111, 4'b1100, 1'b0, 2'd1); endfunction
  function automatic logic [W-1:0] w_ms(logic [1:0] st); return mk(1'b0, 4'b0001, 4'b0001, 1'b0, st); endfunction
  function automatic logic [W-1:0] w_mwr();        return mk(1'b1, 4'b1111, 4'b0000, 1'b0, 2'd2); endfunction
  function automatic logic [W-1:0] w_halt();       return mk(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3); endfunction

  // ---------------- driver tasks ----------------
  // Inputs are already set by the caller; queue the expected word and advance one cycle.
  task automatic step(input logic [W-1:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_load = 1'b0;
    ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e, a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err, dbg_state};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %b, expected %b", nm, a, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    step(w_init(), "reset_held");
    clear = 1'b0;
    for (int i = 0; i < 4; i++) step(w_init(), "init_flush");
    step(w_run(1'b0), "run_idle");

    // Load-use through rs, then through rt, and the reg-0 / unused-source cases.
    ex_load = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    step(w_lu(), "ld_use_rs");
    ex_load = 1'b0;
    step(w_run(1'b0), "ld_use_gone");
    ex_load = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    step(w_run(1'b0), "ld_use_r0");
    ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_use_rt = 1'b1;
    step(w_lu(), "ld_use_rt");
    id_use_rt = 1'b0;
    step(w_run(1'b0), "ld_use_rt_unused");

    // Branch beats load-use.
    id_use_rt = 1'b1; ex_br_taken = 1'b1;
    step(w_br(), "branch_over_lu");
    idle_inputs();

    // Three frozen cycles (branch ignored in the first), resume on the fourth.
    mem_req = 1'b1; ex_br_taken = 1'b1;
    step(w_ms(2'd1), "mem_stall_1");
    ex_br_taken = 1'b0;
    step(w_ms(2'd2), "mem_stall_2");
    step(w_ms(2'd2), "mem_stall_3");
    mem_ready = 1'b1;
    step(w_mwr(), "mem_resume");
    mem_req = 1'b1;
    step(w_run(1'b0), "mem_single_cycle");
    idle_inputs();
    step(w_run(1'b0), "run_after_mem");
`ifdef STALL_CNT_EN
    check_val("stall_cnt_lu_mem", stall_cnt, 32'd5);
`endif

    // Clear mid-run: INIT values immediately.
    clear = 1'b1;
    #1;
`ifdef STALL_CNT_EN
    check_val("stall_cnt_clear", stall_cnt, 32'd0);
`endif
    step(w_init(), "clear_mid_run");
    clear = 1'b0;
    for (int i = 0; i < 4; i++) step(w_init(), "reinit_flush");
    step(w_run(1'b0), "rerun");

    // Memory timeout: 15 low cycles then HALT with sticky mem_err.
    mem_req = 1'b1;
    step(w_ms(2'd1), "tmo_first");
    for (int i = 0; i < 14; i++) step(w_ms(2'd2), "tmo_wait");
    step(w_halt(), "halt_entry");
    mem_ready = 1'b1;
    step(w_halt(), "halt_ready_ignored");
    idle_inputs();
    ex_br_taken = 1'b1;
    step(w_halt(), "halt_sticky");
`ifdef STALL_CNT_EN
    check_val("stall_cnt_tmo", stall_cnt, 32'd15);
`endif
    idle_inputs();

    // Only clear leaves HALT; mem_err drops.
    clear = 1'b1;
    step(w_init(), "clear_from_halt");
    clear = 1'b0;
    for (int i = 0; i < 4; i++) step(w_init(), "final_init");
    step(w_run(1'b0), "final_run");

    @(negedge clk);
    stim_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: run did not finish, %0d words pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
